// File: rtl/spi_tx_arbiter_pkg.sv
// spi_pkg: shared types and defaults for the SPI transmit arbiter family.
//   arb_state_t  - arbiter FSM encoding (IDLE, SETUP, XFER, GAP)
//   idx_w()      - index width for an n-entry vector (never below 1 bit)
//   SPI_*        - default widths/timings shared with the transmitter
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        XFER  = 2'd2,
        GAP   = 2'd3
    } arb_state_t;

    // Width needed to index n entries; a 1-entry vector still gets 1 bit so
    // that counters and ports never collapse to zero width.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int SPI_DATA_W     = 8;
    localparam int SPI_NUM_REQ    = 4;
    localparam int SPI_MAX_BURST  = 16;
    localparam int SPI_GAP_CYCLES = 2;

endpackage

// File: rtl/spi_tx_arbiter_if.sv
// spi_tx_arbiter_if: requester-side and transmitter-side bundle of the arbiter.
//   req_valid/req_last/req_data/req_ready - P_NUM_REQ valid/ready sources,
//                                           requester i in req_data[i*W +: W]
//   tx_valid/tx_data/tx_ready             - single frame stream to the SPI TX
//   cs_n, grant_id, busy                  - chip selects and status
// master: the arbiter.  slave: requesters + transmitter (environment side).
interface spi_tx_arbiter_if
    import spi_pkg::*;
#(
    parameter int P_DATA_WIDTH = SPI_DATA_W,
    parameter int P_NUM_REQ    = SPI_NUM_REQ
);
    localparam int IW = idx_w(P_NUM_REQ);

    logic [P_NUM_REQ-1:0]              req_valid;
    logic [P_NUM_REQ-1:0]              req_last;
    logic [P_NUM_REQ*P_DATA_WIDTH-1:0] req_data;
    logic [P_NUM_REQ-1:0]              req_ready;
    logic                              tx_valid;
    logic [P_DATA_WIDTH-1:0]           tx_data;
    logic                              tx_ready;
    logic [P_NUM_REQ-1:0]              cs_n;
    logic [IW-1:0]                     grant_id;
    logic                              busy;

    modport master (
        input  req_valid, req_last, req_data, tx_ready,
        output req_ready, tx_valid, tx_data, cs_n, grant_id, busy
    );

    modport slave (
        output req_valid, req_last, req_data, tx_ready,
        input  req_ready, tx_valid, tx_data, cs_n, grant_id, busy
    );

endinterface

// File: rtl/spi_tx_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin picker.
//   req     - request vector
//   ptr     - index of the last winner; search starts at (ptr+1) mod N
//   gnt     - one-hot winner (all zero when nothing requests)
//   gnt_idx - index of the winner (0 when nothing requests)
//   any_req - at least one request is set
module rr_arbiter
    import spi_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]        req,
    input  logic [idx_w(N)-1:0] ptr,
    output logic [N-1:0]        gnt,
    output logic [idx_w(N)-1:0] gnt_idx,
    output logic                any_req
);
    localparam int IW = idx_w(N);

    logic found;
    int   idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        any_req = |req;
        // Walk N positions after the pointer; the last winner is visited last.
        for (int k = 1; k <= N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!found && req[IW'(idx)]) begin
                found           = 1'b1;
                gnt[IW'(idx)]   = 1'b1;
                gnt_idx         = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/spi_tx_arbiter.sv
// spi_tx_arbiter: shares one SPI transmitter among P_NUM_REQ sources.
// Round-robin grant held for a whole burst (req_last or P_MAX_BURST beats),
// one cycle of CS setup before data, P_GAP_CYCLES of CS-high after a burst.
//   clk_100 - system clock
//   a_rst   - asynchronous reset, active high
//   s_rst   - synchronous reset, active high, same effect at the edge
//   bus     - requester/transmitter bundle (spi_tx_arbiter_if.master)
module spi_tx_arbiter
    import spi_pkg::*;
#(
    parameter int P_DATA_WIDTH = SPI_DATA_W,
    parameter int P_NUM_REQ    = SPI_NUM_REQ,
    parameter int P_MAX_BURST  = SPI_MAX_BURST,
    parameter int P_GAP_CYCLES = SPI_GAP_CYCLES
) (
    input  logic               clk_100,
    input  logic               a_rst,
    input  logic               s_rst,
    spi_tx_arbiter_if.master   bus
);
    localparam int IW = idx_w(P_NUM_REQ);
    localparam int BW = idx_w(P_MAX_BURST);
    localparam int GW = idx_w(P_GAP_CYCLES);

    arb_state_t    state, state_nx;
    logic [IW-1:0] grant_q, grant_nx;
    logic [IW-1:0] rr, rr_nx;
    logic [BW-1:0] beat_cnt, beat_nx;
    logic [GW-1:0] gap_cnt, gap_nx;

    logic [P_NUM_REQ-1:0] arb_gnt;
    logic [IW-1:0]        arb_idx;
    logic                 any_req;
    logic                 beat;

    // Per-requester frame slices so the grant index selects a whole word.
    logic [P_DATA_WIDTH-1:0] slice [P_NUM_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < P_NUM_REQ; gi++) begin : g_slice
            assign slice[gi] = bus.req_data[gi*P_DATA_WIDTH +: P_DATA_WIDTH];
        end
    endgenerate

    rr_arbiter #(.N(P_NUM_REQ)) u_rr (
        .req     (bus.req_valid),
        .ptr     (rr),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx),
        .any_req (any_req)
    );

    always_ff @(posedge clk_100 or posedge a_rst) begin
        if (a_rst) begin
            state    <= IDLE;
            grant_q  <= '0;
            rr       <= '0;
            beat_cnt <= '0;
            gap_cnt  <= '0;
        end else if (s_rst) begin
            state    <= IDLE;
            grant_q  <= '0;
            rr       <= '0;
            beat_cnt <= '0;
            gap_cnt  <= '0;
        end else begin
            state    <= state_nx;
            grant_q  <= grant_nx;
            rr       <= rr_nx;
            beat_cnt <= beat_nx;
            gap_cnt  <= gap_nx;
        end
    end

    always_comb begin
        state_nx      = state;
        grant_nx      = grant_q;
        rr_nx         = rr;
        beat_nx       = beat_cnt;
        gap_nx        = gap_cnt;
        beat          = 1'b0;
        bus.cs_n      = '1;
        bus.tx_valid  = 1'b0;
        bus.tx_data   = '0;
        bus.req_ready = '0;

        case (state)
            IDLE: begin
                if (any_req) begin
                    grant_nx = arb_idx;
                    state_nx = SETUP;
                end
            end

            SETUP: begin
                bus.cs_n[grant_q] = 1'b0;
                state_nx          = XFER;
            end

            XFER: begin
                // Straight pass-through of the granted stream; a stalled or
                // idle requester keeps the grant and CS.
                bus.cs_n[grant_q]      = 1'b0;
                bus.tx_valid           = bus.req_valid[grant_q];
                bus.tx_data            = slice[grant_q];
                bus.req_ready[grant_q] = bus.tx_ready;
                beat                   = bus.req_valid[grant_q] && bus.tx_ready;
                if (beat) begin
                    if (bus.req_last[grant_q] ||
                        beat_cnt == BW'(P_MAX_BURST - 1)) begin
                        state_nx = GAP;
                        rr_nx    = grant_q;
                        beat_nx  = '0;
                        gap_nx   = '0;
                    end else begin
                        beat_nx = beat_cnt + 1'b1;
                    end
                end
            end

            GAP: begin
                if (gap_cnt == GW'(P_GAP_CYCLES - 1)) begin
                    state_nx = IDLE;
                    gap_nx   = '0;
                end else begin
                    gap_nx = gap_cnt + 1'b1;
                end
            end

            default: state_nx = IDLE;
        endcase
    end

    assign bus.grant_id = grant_q;
    assign bus.busy     = (state != IDLE);

endmodule

// File: tb/tb_spi_tx_arbiter.sv
// tb_spi_tx_arbiter: directed bench for spi_tx_arbiter (N=4, W=8, burst 16,
// gap 2). Inputs change 1 ns after the rising edge, outputs are checked 1 ns
// later; every expected value is written out by hand.
module tb_spi_tx_arbiter;
    import spi_pkg::*;

    logic clk_100;
    logic a_rst;
    logic s_rst;

    int n_vec = 0;
    int n_err = 0;

    spi_tx_arbiter_if #(.P_DATA_WIDTH(8), .P_NUM_REQ(4)) bus ();

    spi_tx_arbiter #(
        .P_DATA_WIDTH (8),
        .P_NUM_REQ    (4),
        .P_MAX_BURST  (16),
        .P_GAP_CYCLES (2)
    ) dut (
        .clk_100 (clk_100),
        .a_rst   (a_rst),
        .s_rst   (s_rst),
        .bus     (bus)
    );

    initial clk_100 = 1'b0;
    always #5 clk_100 = ~clk_100;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk_100);
        #1;
    endtask

    function automatic logic [3:0] csn(input int r);
        logic [3:0] m;
        m = 4'b0001 << r;
        return ~m;
    endfunction

    // One burst from requester r starting in IDLE with r the only requester.
    // rdy_pat gives tx_ready per XFER cycle; valid drops for vg_len cycles
    // before beat vg_at; 'other' requesters turn valid once the grant is held.
    task automatic drive_burst(input int r, input int nb, input logic [7:0] base,
                               input logic [15:0] rdy_pat, input int vg_at,
                               input int vg_len, input logic [3:0] other);
        int k, xc, gl;
        logic vnow;
        logic [3:0] own;
        own = 4'b0001 << r;
        k = 0; xc = 0; gl = vg_len;
        bus.req_valid = own;
        bus.req_data[r*8 +: 8] = base;
        bus.req_last = '0;
        bus.tx_ready = 1'b1;
        #1;
        tick(); #1;
        chk("bst_setup_csn", bus.cs_n, csn(r));
        chk("bst_setup_txv", bus.tx_valid, 0);
        chk("bst_gid", bus.grant_id, r);
        tick();
        while (k < nb && xc < 64) begin
            vnow = 1'b1;
            if (k == vg_at && gl > 0) begin
                vnow = 1'b0;
                gl--;
            end
            bus.req_valid = other | (vnow ? own : 4'b0000);
            bus.req_data[r*8 +: 8] = base + 8'(k);
            bus.req_last = (k == nb - 1) ? own : 4'b0000;
            bus.tx_ready = rdy_pat[4'(xc)];
            #1;
            chk("bst_csn", bus.cs_n, csn(r));
            chk("bst_rdy", bus.req_ready, bus.tx_ready ? own : 4'b0000);
            chk("bst_txv", bus.tx_valid, vnow);
            if (vnow) chk("bst_txd", bus.tx_data, base + 8'(k));
            tick();
            if (vnow && bus.tx_ready) k++;
            xc++;
        end
        chk("bst_beats", k, nb);
        bus.req_valid = '0;
        bus.req_last = '0;
        #1;
        chk("bst_gap_csn", bus.cs_n, 4'b1111);
        chk("bst_gap_rdy", bus.req_ready, 4'b0000);
        tick(); tick(); #1;
        chk("bst_idle_busy", bus.busy, 0);
    endtask

    int exp_g [8] = '{1, 2, 3, 0, 1, 2, 3, 0};

    initial begin
        int n, sent, bursts;
        int bb [2];
        logic prev_low, cs_low;

        a_rst = 1'b1; s_rst = 1'b0;
        bus.req_valid = '0; bus.req_last = '0; bus.req_data = '0; bus.tx_ready = 1'b0;
        repeat (2) @(posedge clk_100);
        #1;
        chk("rst_csn", bus.cs_n, 4'b1111);
        chk("rst_txv", bus.tx_valid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_gid", bus.grant_id, 0);
        chk("rst_rdy", bus.req_ready, 0);
        chk("rst_txd", bus.tx_data, 0);
        a_rst = 1'b0;
        tick();

        // Single requester 2, three beats 05/06/07, then gap and regrant.
        bus.req_valid = 4'b0100; bus.req_data[23:16] = 8'h05; bus.tx_ready = 1'b1;
        #1; chk("t1_idle_csn", bus.cs_n, 4'b1111);
        tick(); #1;
        chk("t1_setup_csn", bus.cs_n, 4'b1011);
        chk("t1_setup_txv", bus.tx_valid, 0);
        chk("t1_setup_rdy", bus.req_ready, 0);
        chk("t1_setup_txd", bus.tx_data, 0);
        chk("t1_gid", bus.grant_id, 2);
        tick(); #1;
        chk("t1_b1_csn", bus.cs_n, 4'b1011);
        chk("t1_b1_txd", bus.tx_data, 8'h05);
        chk("t1_b1_rdy", bus.req_ready, 4'b0100);
        tick(); bus.req_data[23:16] = 8'h06; #1;
        chk("t1_b2_txd", bus.tx_data, 8'h06);
        tick(); bus.req_data[23:16] = 8'h07; bus.req_last = 4'b0100; #1;
        chk("t1_b3_txd", bus.tx_data, 8'h07);
        chk("t1_b3_csn", bus.cs_n, 4'b1011);
        tick(); bus.req_valid = 4'b1000; bus.req_last = '0; bus.req_data[31:24] = 8'h33; #1;
        chk("t1_gap1_csn", bus.cs_n, 4'b1111);
        chk("t1_gap1_rdy", bus.req_ready, 0);
        chk("t1_gap1_txd", bus.tx_data, 0);
        chk("t1_gap1_gid", bus.grant_id, 2);
        chk("t1_gap1_busy", bus.busy, 1);
        tick(); #1;
        chk("t1_gap2_csn", bus.cs_n, 4'b1111);
        tick(); #1;
        chk("t1_idle_csn2", bus.cs_n, 4'b1111);
        chk("t1_idle_busy", bus.busy, 0);
        tick(); #1;
        chk("t1_regrant_csn", bus.cs_n, 4'b0111);
        chk("t1_regrant_gid", bus.grant_id, 3);
        tick(); bus.req_last = 4'b1000; #1;
        chk("t1_r3_txd", bus.tx_data, 8'h33);
        tick(); bus.req_valid = '0; bus.req_last = '0;
        tick(); tick(); #1;
        chk("t1_end_busy", bus.busy, 0);

        // Fairness: everyone valid, one-beat bursts, order 1,2,3,0,...
        s_rst = 1'b1; tick(); s_rst = 1'b0;
        bus.req_valid = 4'b1111; bus.req_last = 4'b1111;
        bus.req_data = 32'h13121110; bus.tx_ready = 1'b1;
        n = 0;
        for (int cyc = 0; cyc < 100 && n < 8; cyc++) begin
            #1;
            if (bus.tx_valid && bus.tx_ready) begin
                chk("fair_gid", bus.grant_id, exp_g[n]);
                chk("fair_txd", bus.tx_data, 32'h10 + exp_g[n]);
                n++;
            end
            tick();
        end
        chk("fair_n", n, 8);
        bus.req_valid = '0; bus.req_last = '0;
        s_rst = 1'b1; tick(); s_rst = 1'b0;

        // Burst limit: requester 0 offers 20 beats, last only on the 20th.
        sent = 0; bursts = 0; bb[0] = 0; bb[1] = 0; prev_low = 1'b0;
        for (int cyc = 0; cyc < 300 && sent < 20; cyc++) begin
            bus.req_valid = 4'b0001;
            bus.req_data[7:0] = 8'h40 + 8'(sent);
            bus.req_last = (sent == 19) ? 4'b0001 : 4'b0000;
            #1;
            cs_low = (bus.cs_n == 4'b1110);
            if (cs_low && !prev_low) bursts++;
            prev_low = cs_low;
            if (bus.tx_valid && bus.tx_ready) begin
                chk("lim_txd", bus.tx_data, 8'h40 + 8'(sent));
                if (bursts >= 1 && bursts <= 2) bb[bursts-1]++;
                sent++;
            end
            tick();
        end
        chk("lim_sent", sent, 20);
        chk("lim_bursts", bursts, 2);
        chk("lim_b0", bb[0], 16);
        chk("lim_b1", bb[1], 4);
        bus.req_valid = '0; bus.req_last = '0;
        tick(); tick(); #1;
        chk("lim_idle_busy", bus.busy, 0);

        // Backpressure: tx_ready 1,0,0,1,1,... on requester 1.
        drive_burst(1, 5, 8'h60, 16'hFFF9, -1, 0, 4'b0000);

        // Valid gap: requester 3 idles 5 cycles before beat 2; 0 and 2 wait.
        drive_burst(3, 4, 8'hA0, 16'hFFFF, 2, 5, 4'b0101);

        // Async reset mid-XFER, then restart from rr=0 (requester 1 wins).
        bus.req_valid = 4'b0100; bus.req_data[23:16] = 8'h77; bus.tx_ready = 1'b0;
        #1;
        tick(); tick(); #1;
        chk("ar_pre_txv", bus.tx_valid, 1);
        chk("ar_pre_csn", bus.cs_n, 4'b1011);
        #2; a_rst = 1'b1; #1;
        chk("ar_csn", bus.cs_n, 4'b1111);
        chk("ar_txv", bus.tx_valid, 0);
        chk("ar_busy", bus.busy, 0);
        chk("ar_rdy", bus.req_ready, 0);
        chk("ar_gid", bus.grant_id, 0);
        #1; a_rst = 1'b0;
        bus.req_valid = 4'b0111; bus.req_data[15:8] = 8'h31;
        tick(); #1;
        chk("ar_rr_gid", bus.grant_id, 1);
        chk("ar_rr_csn", bus.cs_n, 4'b1101);
        tick(); #1;
        chk("sr_pre_txv", bus.tx_valid, 1);
        chk("sr_pre_txd", bus.tx_data, 8'h31);
        s_rst = 1'b1; #1;
        chk("sr_hold_csn", bus.cs_n, 4'b1101);
        tick(); #1;
        chk("sr_csn", bus.cs_n, 4'b1111);
        chk("sr_txv", bus.tx_valid, 0);
        chk("sr_busy", bus.busy, 0);
        chk("sr_gid", bus.grant_id, 0);
        chk("sr_rdy", bus.req_ready, 0);
        s_rst = 1'b0;
        tick(); #1;
        chk("sr_rr_gid", bus.grant_id, 1);
        bus.req_valid = '0;
        s_rst = 1'b1; tick(); s_rst = 1'b0; #1;
        chk("end_busy", bus.busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/spi_tx_arbiter.md
Name: spi_tx_arbiter

Overview:
- Shares one SPI transmitter among P_NUM_REQ data sources.
- Sources include data formers and test sequencers.
- Performs round-robin arbitration and holds the grant for a whole burst, up to an end-of-burst marker or a beat limit.
- Drives one-hot chip selects and enforces CS setup and inter-burst gap timing.
- Sits between the requesters' valid/ready/data outputs and the transmitter's valid/ready/data input.

Parameters:
- P_DATA_WIDTH, 8: width of one SPI frame.
- P_NUM_REQ, 4: number of requesters, 2..8.
- P_MAX_BURST, 16: maximum beats per grant, at least 1.
- P_GAP_CYCLES, 2: cycles CS stays deasserted after a burst, at least 1.

Ports:
- clk_100, in, 1: system clock, 100 MHz.
- a_rst, in, 1: reset, asynchronous, active-high.
- s_rst, in, 1: synchronous reset, active-high; same effect as a_rst at the clock edge.
- req_valid, in, P_NUM_REQ: per-requester data valid.
- req_last, in, P_NUM_REQ: per-requester end-of-burst flag, sampled with the beat.
- req_data, in, P_NUM_REQ*P_DATA_WIDTH: requester i occupies bits [i*W +: W].
- req_ready, out, P_NUM_REQ: per-requester ready.
- tx_valid, out, 1: frame valid to the transmitter.
- tx_data, out, P_DATA_WIDTH: frame to the transmitter.
- tx_ready, in, 1: transmitter can accept a frame.
- cs_n, out, P_NUM_REQ: active-low chip select, one-hot-low while granted.
- grant_id, out, clog2(P_NUM_REQ): index of the current or last grant.
- busy, out, 1: high in any state other than IDLE.

Behaviour:
- Reset values (a_rst or s_rst):
  - state=IDLE, cs_n all ones, grant_id=0, rr pointer=0, beat_cnt=0, gap_cnt=0.
  - req_ready=0, tx_valid=0, busy=0.
- Beat definition: tx_valid && tx_ready in XFER.
- States:
  - IDLE:
    - All cs_n high.
    - If any req_valid is set, pick the first set bit searching from index (rr+1) mod N upward with wrap; rr=0 after reset means requester 1 has first priority.
    - Latch grant_id and go to SETUP on the same edge.
    - No req_valid: stay in IDLE.
  - SETUP:
    - Exactly 1 cycle. cs_n[grant_id] is low; tx_valid=0; req_ready=0.
    - Always goes to XFER.
  - XFER:
    - tx_valid = req_valid[grant_id]; tx_data = the granted slice.
    - req_ready[grant_id] = tx_ready; all other req_ready bits are 0. Combinational, zero added latency.
    - beat_cnt increments on each beat.
    - Exit to GAP on a beat where req_last[grant_id]=1, or where beat_cnt reaches P_MAX_BURST-1.
    - On exit, rr=grant_id and beat_cnt=0.
    - If req_valid drops mid-burst, the arbiter stays in XFER with CS held. The grant is never revoked by the arbiter.
  - GAP:
    - All cs_n high; req_ready=0.
    - Count P_GAP_CYCLES cycles, then go to IDLE. Re-arbitration happens in IDLE, so the minimum CS-high time is P_GAP_CYCLES+1 cycles.
- Simultaneous requests: resolved by round-robin only. A requester that has just been served has the lowest priority next time.
- Burst limit: a requester continuing past P_MAX_BURST beats loses the grant. Its remaining data waits for re-arbitration. req_last is not implied at the limit.
- Reset mid-burst: immediate return to reset values (a_rst asynchronously, s_rst on the edge). The in-flight beat is dropped, and the transmitter sees tx_valid fall.
- req_valid on non-granted requesters is ignored and their req_ready stays 0; they must hold data per valid/ready rules.
- tx_data in states other than XFER: all zeros.
- grant_id holds its value through GAP and IDLE until the next grant.

Decomposition:
- Package spi_pkg:
  - typedef arb_state_t {IDLE, SETUP, XFER, GAP}.
  - Function clog2-based width helper.
  - Default-width localparams shared with the transmitter.
- Sub-module rr_arbiter: combinational.
  - Inputs: req vector, rr pointer.
  - Outputs: one-hot grant, grant index, any_req.
  - Reusable by other shared-resource blocks.

Test Plan:
1. Single requester: N=4, requester 2 sends 3 beats, last on beat 3, tx_ready=1.
   - cs_n=4'b1011 from SETUP through the 3rd beat.
   - tx_data sequence 0x05, 0x06, 0x07.
   - Then cs_n=4'b1111 for 3 cycles (2 GAP + 1 IDLE) before any new CS.
2. Fairness: all 4 requesters continuously valid with 1-beat bursts.
   - Grant order after reset: 1, 2, 3, 0, 1, …
   - No requester is granted twice in any window of 4 grants.
3. Burst limit: P_MAX_BURST=16, requester 0 holds valid for 20 beats with no last.
   - Exactly 16 beats are accepted, then GAP.
   - If others are idle, requester 0 is regranted and sends the remaining 4.
4. Backpressure: tx_ready toggles 1,0,0,1 mid-burst.
   - req_ready mirrors tx_ready.
   - Data is held; no beat is lost or duplicated; beat_cnt advances only on handshakes.
5. Resets:
   - a_rst pulsed mid-XFER between edges: cs_n=4'b1111, tx_valid=0 immediately.
   - s_rst asserted for 1 cycle: same values at the next edge.
   - After release, arbitration restarts from rr=0.
6. Valid gap: the granted requester drops req_valid for 5 cycles mid-burst.
   - State stays XFER and CS stays low.
   - Other requesters keep req_ready=0.
